line_fifo: RTL and testbench

LINE_FIFO -- requirements
Module: line_fifo

---
 rtl/line_fifo.sv | 103 ++++++++++
 tb/tb_line_fifo.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/line_fifo.sv
// First-word-fall-through FIFO of line primitives (two endpoints plus colour).
// Sticky overflow/underflow flags, synchronous flush, asynchronous active-low reset.
module line_fifo #(
  parameter int COORD_W  = 11,
  parameter int COLOR_W  = 3,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic [COORD_W-1:0] wr_start_x,
  input  logic [COORD_W-1:0] wr_start_y,
  input  logic [COORD_W-1:0] wr_end_x,
  input  logic [COORD_W-1:0] wr_end_y,
  input  logic [COLOR_W-1:0] wr_color,
  input  logic               wr,
  input  logic               rd,
  input  logic               flush,
  input  logic               clr_err,
  output logic [COORD_W-1:0] rd_start_x,
  output logic [COORD_W-1:0] rd_start_y,
  output logic [COORD_W-1:0] rd_end_x,
  output logic [COORD_W-1:0] rd_end_y,
  output logic [COLOR_W-1:0] rd_color,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic [$clog2(DEPTH):0] count,
  output logic               overflow,
  output logic               underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 4 * COORD_W + COLOR_W;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
      (AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_param_check
    $fatal(1, "line_fifo: DEPTH must be a power of two >= 2 and AF_LEVEL within 1..DEPTH");
  end

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [EW-1:0] head_entry;
  logic          push;
  logic          pop;
  logic          ovf_evt;
  logic          unf_evt;

  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign almost_full = (count >= CW'(AF_LEVEL));

  // A full FIFO still accepts a write when the same cycle pops the head.
  always_comb begin
    push    = 1'b0;
    pop     = 1'b0;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    if (!flush) begin
      pop     = rd & ~empty;
      push    = wr & (~full | rd);
      ovf_evt = wr & full & ~rd;
      unf_evt = rd & empty;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (pop)  head <= head + AW'(1);
        if (push) tail <= tail + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
      overflow  <= ovf_evt | (overflow  & ~clr_err);
      underflow <= unf_evt | (underflow & ~clr_err);
    end
  end

  // Entry storage carries no reset; its contents are masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= {wr_start_x, wr_start_y, wr_end_x, wr_end_y, wr_color};
  end

  assign head_entry = empty ? '0 : mem[head];
  assign rd_start_x = head_entry[EW-1 -: COORD_W];
  assign rd_start_y = head_entry[EW-1-COORD_W -: COORD_W];
  assign rd_end_x   = head_entry[EW-1-2*COORD_W -: COORD_W];
  assign rd_end_y   = head_entry[EW-1-3*COORD_W -: COORD_W];
  assign rd_color   = head_entry[COLOR_W-1:0];

endmodule

// File: tb/tb_line_fifo.sv
// Directed self-checking bench for line_fifo at default parameters
// (COORD_W=11, COLOR_W=3, DEPTH=16, AF_LEVEL=14).
module tb_line_fifo;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [10:0] wr_start_x, wr_start_y, wr_end_x, wr_end_y;
  logic [2:0]  wr_color;
  logic        wr, rd, flush, clr_err;
  logic [10:0] rd_start_x, rd_start_y, rd_end_x, rd_end_y;
  logic [2:0]  rd_color;
  logic        full, empty, almost_full;
  logic [4:0]  count;
  logic        overflow, underflow;

  int vectors = 0;
  int miscompares = 0;

  line_fifo dut (
    .clk(clk), .rst_b(rst_b),
    .wr_start_x(wr_start_x), .wr_start_y(wr_start_y),
    .wr_end_x(wr_end_x), .wr_end_y(wr_end_y), .wr_color(wr_color),
    .wr(wr), .rd(rd), .flush(flush), .clr_err(clr_err),
    .rd_start_x(rd_start_x), .rd_start_y(rd_start_y),
    .rd_end_x(rd_end_x), .rd_end_y(rd_end_y), .rd_color(rd_color),
    .full(full), .empty(empty), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line fields derived from start_x so every field is distinguishable.
  function automatic logic [10:0] ey(input logic [10:0] x);
    return x + 11'h300;
  endfunction

  task automatic put(input logic [10:0] x, input logic [2:0] c);
    wr_start_x = x;
    wr_start_y = x + 11'h100;
    wr_end_x   = x + 11'h200;
    wr_end_y   = ey(x);
    wr_color   = c;
    wr         = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; flush = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    rst_b = 1'b0;
    wr = 1'b0; rd = 1'b0; flush = 1'b0; clr_err = 1'b0;
    wr_start_x = '0; wr_start_y = '0; wr_end_x = '0; wr_end_y = '0; wr_color = '0;
    #3;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_af", 32'(almost_full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_unf", 32'(underflow), 32'd0);
    check("rst_rdx", 32'(rd_start_x), 32'd0);
    #9 rst_b = 1'b1;

    // Three lines in, three out in order
    for (int i = 1; i <= 3; i++) begin
      put(11'(i), 3'(i));
      tick();
      check("w3_count", 32'(count), 32'(i));
      check("w3_head", 32'(rd_start_x), 32'd1);
    end
    for (int i = 1; i <= 3; i++) begin
      check("r3_sx", 32'(rd_start_x), 32'(i));
      check("r3_sy", 32'(rd_start_y), 32'(i + 'h100));
      check("r3_ex", 32'(rd_end_x), 32'(i + 'h200));
      check("r3_ey", 32'(rd_end_y), 32'(i + 'h300));
      check("r3_col", 32'(rd_color), 32'(i));
      rd = 1'b1;
      tick();
      check("r3_count", 32'(count), 32'(3 - i));
    end
    check("r3_empty", 32'(empty), 32'd1);
    check("r3_zero_x", 32'(rd_start_x), 32'd0);
    check("r3_zero_col", 32'(rd_color), 32'd0);

    // Fill to DEPTH, almost_full threshold, overflow on 17th
    for (int i = 0; i < 16; i++) begin
      put(11'(16 + i), 3'(i));
      tick();
      check("fill_count", 32'(count), 32'(i + 1));
      if (i == 12) check("af_at13", 32'(almost_full), 32'd0);
      if (i == 13) check("af_at14", 32'(almost_full), 32'd1);
    end
    check("fill_full", 32'(full), 32'd1);
    put(11'h055, 3'd0);
    tick();
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_head", 32'(rd_start_x), 32'd16);
    clr_err = 1'b1;
    tick();
    check("clr_ovf", 32'(overflow), 32'd0);

    // Simultaneous pop and push while full
    put(11'h7FF, 3'd7);
    rd = 1'b1;
    tick();
    check("fullrw_count", 32'(count), 32'd16);
    check("fullrw_ovf", 32'(overflow), 32'd0);
    check("fullrw_head", 32'(rd_start_x), 32'd17);
    for (int i = 0; i < 16; i++) begin
      logic [10:0] ex;
      logic [2:0]  ec;
      ex = (i < 15) ? 11'(17 + i) : 11'h7FF;
      ec = (i < 15) ? 3'(i + 1) : 3'd7;
      check("drain_sx", 32'(rd_start_x), 32'(ex));
      check("drain_ey", 32'(rd_end_y), 32'(ey(ex)));
      check("drain_col", 32'(rd_color), 32'(ec));
      rd = 1'b1;
      tick();
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_unf", 32'(underflow), 32'd0);

    // Read and write on empty
    rd = 1'b1;
    put(11'h0AB, 3'd5);
    tick();
    check("erw_unf", 32'(underflow), 32'd1);
    check("erw_count", 32'(count), 32'd1);
    check("erw_col", 32'(rd_color), 32'd5);
    check("erw_sx", 32'(rd_start_x), 32'h0AB);
    rd = 1'b1;
    tick();
    check("erw_empty", 32'(empty), 32'd1);
    clr_err = 1'b1;
    tick();
    check("erw_clr", 32'(underflow), 32'd0);

    // Flush beats write; set-wins on clr_err
    rd = 1'b1;
    tick();
    check("fl_unf_pre", 32'(underflow), 32'd1);
    for (int i = 0; i < 5; i++) begin
      put(11'(16'h10 + i), 3'd0);
      tick();
    end
    check("fl_count5", 32'(count), 32'd5);
    flush = 1'b1;
    put(11'h099, 3'd1);
    tick();
    check("fl_count", 32'(count), 32'd0);
    check("fl_empty", 32'(empty), 32'd1);
    check("fl_ovf", 32'(overflow), 32'd0);
    check("fl_unf_kept", 32'(underflow), 32'd1);
    clr_err = 1'b1;
    rd = 1'b1;
    tick();
    check("clr_setwins", 32'(underflow), 32'd1);
    clr_err = 1'b1;
    tick();
    check("clr_only", 32'(underflow), 32'd0);
    put(11'h042, 3'd2);
    tick();
    check("postfl_head", 32'(rd_start_x), 32'h042);
    check("postfl_count", 32'(count), 32'd1);
    rd = 1'b1;
    tick();

    // Streaming through pointer wrap, then asynchronous reset
    rd = 1'b1;
    tick();
    check("wrap_unf", 32'(underflow), 32'd1);
    for (int i = 0; i < 3; i++) begin
      put(11'(200 + i), 3'(i));
      tick();
    end
    for (int k = 0; k < 40; k++) begin
      check("wrap_head", 32'(rd_start_x), 32'(200 + k));
      rd = 1'b1;
      put(11'(203 + k), 3'(k));
      tick();
      check("wrap_count", 32'(count), 32'd3);
    end
    #2 rst_b = 1'b0;
    #1;
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_count", 32'(count), 32'd0);
    check("arst_unf", 32'(underflow), 32'd0);
    check("arst_ovf", 32'(overflow), 32'd0);
    check("arst_full", 32'(full), 32'd0);
    check("arst_rdx", 32'(rd_start_x), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    tick();
    check("post_rst_empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
